// File: rtl/bin_pool_pkg.sv
// Shared definitions for the binary max-pool stage.
//   HDR_END       stream sentinel header word
//   N_8/N_10/N_14 legal conv output widths (header values)
//   state_t       sequencing FSM states
//   half_n()      pooled map width for a given input width
//   is_legal_n()  header recognised as an image (anything else ends the stream)
package bin_pool_pkg;

  localparam logic [15:0] HDR_END = 16'h00FF;
  localparam logic [15:0] N_8     = 16'd8;
  localparam logic [15:0] N_10    = 16'd10;
  localparam logic [15:0] N_14    = 16'd14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ROW_A,
    ST_ROW_B,
    ST_DONE
  } state_t;

  function automatic logic [15:0] half_n(input logic [15:0] n);
    return n >> 1;
  endfunction

  function automatic logic is_legal_n(input logic [15:0] n);
    return (n == N_8) || (n == N_10) || (n == N_14);
  endfunction

endpackage

// File: rtl/pool_row_reduce.sv
// Combinational 2x2 reduction of one even/odd row pair.
// Build option: POOL_MAJORITY_EN selects majority (>=2 of 4 bits set);
// default build is OR (binary max).
// Ports:
//   row_a   [MAX_N-1:0]    even input row (already masked to N bits)
//   row_b   [MAX_N-1:0]    odd input row (already masked to N bits)
//   pooled  [MAX_N/2-1:0]  bit j reduces row_a/row_b bits 2j and 2j+1
module pool_row_reduce #(
  parameter int MAX_N = 14
) (
  input  logic [MAX_N-1:0]   row_a,
  input  logic [MAX_N-1:0]   row_b,
  output logic [MAX_N/2-1:0] pooled
);

  for (genvar j = 0; j < MAX_N/2; j++) begin : g_pair
    logic a0, a1, b0, b1;
    assign a0 = row_a[2*j];
    assign a1 = row_a[2*j+1];
    assign b0 = row_b[2*j];
    assign b1 = row_b[2*j+1];
`ifdef POOL_MAJORITY_EN
    // any two of the four set
    assign pooled[j] = (a0 & a1) | (a0 & b0) | (a0 & b1) |
                       (a1 & b0) | (a1 & b1) | (b0 & b1);
`else
    assign pooled[j] = a0 | a1 | b0 | b1;
`endif
  end

endmodule

// File: rtl/bin_maxpool_stage.sv
// Binary 2x2/stride-2 pooling stage. Streams conv feature maps (header N,
// then N row words) from the intermediate SRAM and writes pooled maps
// (header N/2, then N/2 rows) to the output SRAM until a non-image header.
// Build option: POOL_MAJORITY_EN (see pool_row_reduce) changes only the
// reduction, not timing or format.
// Ports:
//   clk                     clock, rising edge
//   reset_b                 asynchronous reset, active low
//   dut_run                 start pulse, honoured only in IDLE
//   dut_busy                high from the cycle after an accepted run until DONE
//   dut_sram_read_address   read address; data returns one cycle later
//   sram_dut_read_data      read data
//   dut_sram_write_address  output SRAM write address (contiguous across images)
//   dut_sram_write_data     output SRAM write data
//   dut_sram_write_enable   one word written per asserted cycle
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for dut_run; address 0 (or next stream) presented
// ST_HDR   | header on read data; legal N -> write N/2, else end stream
// ST_ROW_A | even row on read data, held in row_a
// ST_ROW_B | odd row on read data, pooled word registered for writing
// ST_DONE  | stream finished, busy low, back to IDLE
module bin_maxpool_stage
  import bin_pool_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int MAX_N  = 14
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable
);

  state_t             state;
  logic [3:0]         n_reg;
  logic [3:0]         row_cnt;
  logic [MAX_N-1:0]   row_a;
  logic [MAX_N-1:0]   mask_n;
  logic [MAX_N-1:0]   row_b_masked;
  logic [MAX_N/2-1:0] pooled;
  logic               hdr_is_image;

  // Rows carry garbage above bit N-1; masking here keeps the reduction simple
  // and guarantees pooled bits above N/2-1 come out 0.
  always_comb begin
    mask_n       = MAX_N'((32'd1 << n_reg) - 32'd1);
    row_b_masked = sram_dut_read_data[MAX_N-1:0] & mask_n;
    hdr_is_image = (sram_dut_read_data != HDR_END) && is_legal_n(sram_dut_read_data);
  end

  pool_row_reduce #(
    .MAX_N(MAX_N)
  ) u_reduce (
    .row_a (row_a),
    .row_b (row_b_masked),
    .pooled(pooled)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state                  <= ST_IDLE;
      n_reg                  <= '0;
      row_cnt                <= '0;
      row_a                  <= '0;
      dut_busy               <= 1'b0;
      dut_sram_read_address  <= '0;
      dut_sram_write_address <= '0;
      dut_sram_write_data    <= '0;
      dut_sram_write_enable  <= 1'b0;
    end else begin
      dut_sram_write_enable <= 1'b0;
      // address moves on after the word it pointed at has been written
      if (dut_sram_write_enable)
        dut_sram_write_address <= dut_sram_write_address + 1'b1;

      case (state)
        ST_IDLE: begin
          if (dut_run) begin
            state                 <= ST_HDR;
            dut_busy              <= 1'b1;
            dut_sram_read_address <= dut_sram_read_address + 1'b1;
          end
        end

        ST_HDR: begin
          if (hdr_is_image) begin
            n_reg                 <= sram_dut_read_data[3:0];
            row_cnt               <= '0;
            dut_sram_write_data   <= DATA_W'(half_n(sram_dut_read_data));
            dut_sram_write_enable <= 1'b1;
            dut_sram_read_address <= dut_sram_read_address + 1'b1;
            state                 <= ST_ROW_A;
          end else begin
            // the address already presented for the next word is not consumed
            dut_busy <= 1'b0;
            state    <= ST_DONE;
          end
        end

        ST_ROW_A: begin
          row_a                 <= sram_dut_read_data[MAX_N-1:0] & mask_n;
          row_cnt               <= row_cnt + 1'b1;
          dut_sram_read_address <= dut_sram_read_address + 1'b1;
          state                 <= ST_ROW_B;
        end

        ST_ROW_B: begin
          dut_sram_write_data   <= DATA_W'(pooled);
          dut_sram_write_enable <= 1'b1;
          dut_sram_read_address <= dut_sram_read_address + 1'b1;
          if (row_cnt == (n_reg - 4'd1)) begin
            state <= ST_HDR;
          end else begin
            row_cnt <= row_cnt + 1'b1;
            state   <= ST_ROW_A;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_maxpool_stage.sv
module tb_bin_maxpool_stage;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int MAX_N  = 14;
  localparam int LOG_SZ = 2048;

  logic              clk = 1'b0;
  logic              reset_b = 1'b0;
  logic              dut_run = 1'b0;
  logic              dut_busy;
  logic [ADDR_W-1:0] dut_sram_read_address;
  logic [DATA_W-1:0] sram_dut_read_data;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic [DATA_W-1:0] dut_sram_write_data;
  logic              dut_sram_write_enable;

  bin_maxpool_stage #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_N (MAX_N)
  ) dut (
    .clk                   (clk),
    .reset_b               (reset_b),
    .dut_run               (dut_run),
    .dut_busy              (dut_busy),
    .dut_sram_read_address (dut_sram_read_address),
    .sram_dut_read_data    (sram_dut_read_data),
    .dut_sram_write_address(dut_sram_write_address),
    .dut_sram_write_data   (dut_sram_write_data),
    .dut_sram_write_enable (dut_sram_write_enable)
  );

  always #5 clk = ~clk;

  // intermediate SRAM model, one cycle read latency
  logic [15:0] mem_in [0:4095];
  always @(posedge clk) sram_dut_read_data <= mem_in[dut_sram_read_address];

  // output SRAM write log
  int          wr_count = 0;
  int          viol = 0;
  logic [ADDR_W-1:0] log_addr [0:LOG_SZ-1];
  logic [15:0]       log_data [0:LOG_SZ-1];
  always @(negedge clk) begin
    if (reset_b === 1'b1 && dut_sram_write_enable === 1'b1) begin
      if (wr_count < LOG_SZ) begin
        log_addr[wr_count] = dut_sram_write_address;
        log_data[wr_count] = dut_sram_write_data;
      end
      wr_count++;
      if (dut_busy !== 1'b1) viol++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] stream_words[$];
  logic [15:0] exp_q[$];
  logic [15:0] row_buf [0:15];

  // reference pooling: count the ones in each 2x2 window
  function automatic logic [15:0] ref_pool(input logic [15:0] a, input logic [15:0] b, input int n);
    logic [15:0] res;
    int c;
    res = 16'h0000;
    for (int j = 0; j < n/2; j++) begin
      c = int'(a[2*j]) + int'(a[2*j+1]) + int'(b[2*j]) + int'(b[2*j+1]);
`ifdef POOL_MAJORITY_EN
      res[j] = (c >= 2);
`else
      res[j] = (c >= 1);
`endif
    end
    return res;
  endfunction

  task automatic clear_stream();
    stream_words.delete();
    exp_q.delete();
  endtask

  task automatic add_image(input int n);
    stream_words.push_back(16'(n));
    for (int r = 0; r < n; r++) stream_words.push_back(row_buf[r]);
    exp_q.push_back(16'(n/2));
    for (int k = 0; k < n/2; k++) exp_q.push_back(ref_pool(row_buf[2*k], row_buf[2*k+1], n));
  endtask

  task automatic load_stream(input logic [15:0] sentinel);
    stream_words.push_back(sentinel);
    for (int i = 0; i < 4096; i++) mem_in[i] = 16'h0000;
    for (int i = 0; i < stream_words.size(); i++) mem_in[i] = stream_words[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_b = 1'b0;
    dut_run = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_stream(input int max_cyc, output int busy_cyc, output bit timeout);
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    busy_cyc = 0;
    while (dut_busy === 1'b1 && busy_cyc < max_cyc) begin
      busy_cyc++;
      @(negedge clk);
    end
    timeout = (dut_busy !== 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut_busy !== 1'b0 || dut_sram_write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b we=%b, expected 0/0", dut_busy, dut_sram_write_enable);
    end
    n_checks++;
    if (dut_sram_read_address !== '0 || dut_sram_write_address !== '0 || dut_sram_write_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: ra=%h wa=%h wd=%h, expected all 0",
               dut_sram_read_address, dut_sram_write_address, dut_sram_write_data);
    end
    reset_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_8x8();
    int start, bc, v0;
    bit to;
    logic [15:0] e;
    do_reset();
    clear_stream();
    for (int r = 0; r < 8; r++) row_buf[r] = (r % 2 == 0) ? 16'h00AA : 16'h0000;
    add_image(8);
    load_stream(16'h00FF);
    start = wr_count;
    v0 = viol;
    run_stream(100, bc, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL single_timeout: busy still %b", dut_busy); end
    n_checks++;
    if (bc != 10) begin n_fail++; $display("FAIL single_busy_len: got %0d cycles, expected 10", bc); end
    n_checks++;
    if (wr_count - start != 5) begin
      n_fail++;
      $display("FAIL single_count: got %0d writes, expected 5", wr_count - start);
    end
    for (int i = 0; i < 5; i++) begin
      e = (i == 0) ? 16'h0004 : 16'h000F;
      n_checks++;
      if (log_addr[start+i] !== ADDR_W'(i) || log_data[start+i] !== e) begin
        n_fail++;
        $display("FAIL single_word[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 i, log_addr[start+i], log_data[start+i], i, e);
      end
    end
    n_checks++;
    if (dut_sram_read_address !== ADDR_W'(10)) begin
      n_fail++;
      $display("FAIL single_rd_addr: got %0d, expected 10", dut_sram_read_address);
    end
    n_checks++;
    if (viol != v0) begin n_fail++; $display("FAIL single_we_busy: got %0d writes outside busy, expected 0", viol - v0); end
  endtask

  task automatic test_back_to_back();
    int start, bc;
    bit to;
    logic [15:0] e;
    do_reset();
    clear_stream();
    for (int r = 0; r < 16; r++) row_buf[r] = 16'h0000;
    add_image(10);
    row_buf[13] = 16'h2000;
    add_image(14);
    load_stream(16'h00FF);
    start = wr_count;
    run_stream(200, bc, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL b2b_timeout: busy still %b", dut_busy); end
    n_checks++;
    if (wr_count - start != 14) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d writes, expected 14", wr_count - start);
    end
    for (int i = 0; i < 14; i++) begin
      e = (i == 0) ? 16'h0005 : (i == 6) ? 16'h0007 : (i == 13) ? 16'h0040 : 16'h0000;
      n_checks++;
      if (log_addr[start+i] !== ADDR_W'(i) || log_data[start+i] !== e) begin
        n_fail++;
        $display("FAIL b2b_word[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 i, log_addr[start+i], log_data[start+i], i, e);
      end
    end
    n_checks++;
    if (dut_sram_read_address !== ADDR_W'(27)) begin
      n_fail++;
      $display("FAIL b2b_rd_addr: got %0d, expected 27", dut_sram_read_address);
    end
  endtask

  task automatic test_sentinel_first();
    int start, bc;
    bit to;
    do_reset();
    clear_stream();
    load_stream(16'h00FF);
    start = wr_count;
    run_stream(20, bc, to);
    n_checks++;
    if (to || bc > 3 || bc < 1) begin
      n_fail++;
      $display("FAIL sentinel_busy: got %0d busy cycles (timeout=%0d), expected 1..3", bc, to);
    end
    n_checks++;
    if (wr_count != start) begin
      n_fail++;
      $display("FAIL sentinel_writes: got %0d writes, expected 0", wr_count - start);
    end
    n_checks++;
    if (dut_sram_read_address !== ADDR_W'(1)) begin
      n_fail++;
      $display("FAIL sentinel_rd_addr: got %0d, expected 1", dut_sram_read_address);
    end
  endtask

  task automatic test_reduction();
    int start, bc;
    bit to;
    logic [15:0] e;
    logic [15:0] exp_rows [0:3];
`ifdef POOL_MAJORITY_EN
    exp_rows[0] = 16'h0001; exp_rows[1] = 16'h0000; exp_rows[2] = 16'h0000; exp_rows[3] = 16'h0000;
`else
    exp_rows[0] = 16'h0001; exp_rows[1] = 16'h0002; exp_rows[2] = 16'h0001; exp_rows[3] = 16'h0000;
`endif
    do_reset();
    clear_stream();
    row_buf[0] = 16'h0003; row_buf[1] = 16'h0001;
    row_buf[2] = 16'h0004; row_buf[3] = 16'h0000;
    row_buf[4] = 16'h0001; row_buf[5] = 16'h0000;
    row_buf[6] = 16'h0000; row_buf[7] = 16'h0000;
    add_image(8);
    load_stream(16'h00FF);
    start = wr_count;
    run_stream(100, bc, to);
    n_checks++;
    if (to || wr_count - start != 5) begin
      n_fail++;
      $display("FAIL reduce_count: got %0d writes (timeout=%0d), expected 5", wr_count - start, to);
    end
    for (int i = 1; i < 5; i++) begin
      e = exp_rows[i-1];
      n_checks++;
      if (log_data[start+i] !== e) begin
        n_fail++;
        $display("FAIL reduce_row[%0d]: got %h, expected %h", i - 1, log_data[start+i], e);
      end
    end
  endtask

  task automatic test_random();
    int start, bc, nimg, n, total_rd, v0;
    bit to;
    logic [15:0] s;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      clear_stream();
      nimg = $urandom_range(1, 3);
      total_rd = 1;
      for (int m = 0; m < nimg; m++) begin
        case ($urandom_range(0, 2))
          0: n = 8;
          1: n = 10;
          default: n = 14;
        endcase
        for (int r = 0; r < 16; r++) row_buf[r] = 16'($urandom);
        add_image(n);
        total_rd += 1 + n;
      end
      if ($urandom_range(0, 1) == 0) s = 16'h00FF;
      else begin
        s = 16'($urandom);
        while (s == 16'd8 || s == 16'd10 || s == 16'd14) s = 16'($urandom);
      end
      load_stream(s);
      start = wr_count;
      v0 = viol;
      run_stream(400, bc, to);
      n_checks++;
      if (to || wr_count - start != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d writes (timeout=%0d), expected %0d",
                 it, wr_count - start, to, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (log_addr[start+i] !== ADDR_W'(i) || log_data[start+i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_word[%0d]: got addr %0d data %h, expected addr %0d data %h",
                   it, i, log_addr[start+i], log_data[start+i], i, exp_q[i]);
        end
      end
      n_checks++;
      if (dut_sram_read_address !== ADDR_W'(total_rd)) begin
        n_fail++;
        $display("FAIL rand%0d_rd_addr: got %0d, expected %0d", it, dut_sram_read_address, total_rd);
      end
      n_checks++;
      if (viol != v0) begin n_fail++; $display("FAIL rand%0d_we_busy: got %0d, expected 0", it, viol - v0); end
    end
  endtask

  task automatic test_run_while_busy();
    int start, bc, after;
    do_reset();
    clear_stream();
    for (int r = 0; r < 8; r++) row_buf[r] = 16'($urandom) | 16'hFF00;
    add_image(8);
    load_stream(16'h00FF);
    start = wr_count;
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    repeat (3) @(negedge clk);
    dut_run = 1'b1;
    repeat (2) @(negedge clk);
    dut_run = 1'b0;
    bc = 0;
    while (dut_busy === 1'b1 && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    n_checks++;
    if (dut_busy !== 1'b0) begin n_fail++; $display("FAIL busyrun_timeout: busy still %b", dut_busy); end
    repeat (6) @(negedge clk);
    after = wr_count;
    n_checks++;
    if (after - start != exp_q.size() || dut_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busyrun_count: got %0d writes busy=%b, expected %0d writes busy=0",
               after - start, dut_busy, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (log_addr[start+i] !== ADDR_W'(i) || log_data[start+i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL busyrun_word[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 i, log_addr[start+i], log_data[start+i], i, exp_q[i]);
      end
    end
    n_checks++;
    if (dut_sram_read_address !== ADDR_W'(10)) begin
      n_fail++;
      $display("FAIL busyrun_rd_addr: got %0d, expected 10", dut_sram_read_address);
    end
  endtask

  task automatic test_mid_reset();
    int start, bc;
    bit to;
    do_reset();
    clear_stream();
    for (int r = 0; r < 8; r++) row_buf[r] = 16'h00FF;
    add_image(8);
    load_stream(16'h00FF);
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    repeat (4) @(negedge clk);
    reset_b = 1'b0;
    #1;
    n_checks++;
    if (dut_busy !== 1'b0 || dut_sram_write_enable !== 1'b0 || dut_sram_read_address !== '0 ||
        dut_sram_write_address !== '0 || dut_sram_write_data !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: busy=%b we=%b ra=%h wa=%h wd=%h, expected all 0",
               dut_busy, dut_sram_write_enable, dut_sram_read_address,
               dut_sram_write_address, dut_sram_write_data);
    end
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    clear_stream();
    for (int r = 0; r < 10; r++) row_buf[r] = 16'($urandom);
    add_image(10);
    load_stream(16'h0000);
    start = wr_count;
    run_stream(100, bc, to);
    n_checks++;
    if (to || wr_count - start != exp_q.size()) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d writes (timeout=%0d), expected %0d",
               wr_count - start, to, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (log_addr[start+i] !== ADDR_W'(i) || log_data[start+i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midreset_word[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 i, log_addr[start+i], log_data[start+i], i, exp_q[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem_in[i] = 16'h0000;
    test_reset();
    test_single_8x8();
    test_back_to_back();
    test_sentinel_first();
    test_reduction();
    test_random();
    test_run_while_busy();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

endmodule
